// File: rtl/inst_buffer.sv
// inst_buffer: in-order instruction FIFO from icache returns to dual-issue decode, flushable.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int FULL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       wr_valid,
  input  logic [31:0]      wr_pc0,
  input  logic [31:0]      wr_inst0,
  input  logic [31:0]      wr_pc1,
  input  logic [31:0]      wr_inst1,
  input  logic [1:0]       rd_accept,
  output logic [1:0]       rd_valid,
  output logic [31:0]      rd_pc0,
  output logic [31:0]      rd_inst0,
  output logic [31:0]      rd_pc1,
  output logic [31:0]      rd_inst1,
  output logic             ibuffer_full,
  output logic             ibuffer_empty,
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);
  localparam int CW = PTR_W + 1;
  logic [63:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head1, tail1;
  logic [CW-1:0] acc_n, rd_n, wr_n;
  logic [CW:0] free;
  logic wr_ok;
  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;
  assign acc_n = (rd_accept == 2'd0) ? '0 : (rd_accept == 2'd1) ? CW'(1) : CW'(2);
  assign rd_n = (acc_n > count) ? count : acc_n;
  assign wr_n = CW'(wr_valid[0]) + CW'(wr_valid[1]);
  // reads in the same cycle make room for the incoming return
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + {1'b0, rd_n};
  assign wr_ok = {1'b0, wr_n} <= free;
  assign rd_valid = {count >= CW'(2), count >= CW'(1)};
  assign {rd_pc0, rd_inst0} = mem[head];
  assign {rd_pc1, rd_inst1} = mem[head1];
  assign ibuffer_full = count >= CW'(DEPTH - FULL_THRESH);
  assign ibuffer_empty = count == '0;
  always_ff @(posedge clk) begin
    if (!flush && wr_ok) begin
      if (wr_valid[0]) mem[tail] <= {wr_pc0, wr_inst0};
      if (wr_valid[1]) mem[wr_valid[0] ? tail1 : tail] <= {wr_pc1, wr_inst1};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow_err <= 1'b0;
    end else begin
      head <= head + rd_n[PTR_W-1:0];
      tail <= wr_ok ? tail + wr_n[PTR_W-1:0] : tail;
      count <= count + (wr_ok ? wr_n : '0) - rd_n;
      overflow_err <= !wr_ok;
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed scenario tasks for inst_buffer with hand-computed expectations.
module tb_inst_buffer;
  logic clk = 0, rst = 0, flush = 0;
  logic [1:0] wr_valid = 0, rd_accept = 0;
  logic [31:0] wr_pc0 = 0, wr_inst0 = 0, wr_pc1 = 0, wr_inst1 = 0;
  logic [1:0] rd_valid;
  logic [31:0] rd_pc0, rd_inst0, rd_pc1, rd_inst1;
  logic ibuffer_full, ibuffer_empty, overflow_err;
  logic [4:0] count;
  int cmp = 0, bad = 0;

  inst_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid),
    .wr_pc0(wr_pc0), .wr_inst0(wr_inst0), .wr_pc1(wr_pc1), .wr_inst1(wr_inst1),
    .rd_accept(rd_accept), .rd_valid(rd_valid), .rd_pc0(rd_pc0), .rd_inst0(rd_inst0),
    .rd_pc1(rd_pc1), .rd_inst1(rd_inst1), .ibuffer_full(ibuffer_full),
    .ibuffer_empty(ibuffer_empty), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                          input logic [31:0] p1, input logic [31:0] i1);
    wr_valid = v; wr_pc0 = p0; wr_inst0 = i0; wr_pc1 = p1; wr_inst1 = i1;
  endtask

  task automatic do_flush();
    drive_wr(2'b00, 0, 0, 0, 0);
    rd_accept = 0; flush = 1;
    step();
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    drive_wr(2'b11, 32'h1000, 32'h1, 32'h1004, 32'h2);
    repeat (3) step();
    cmp++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    cmp++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL reset_rd_valid: got %b want 00", rd_valid); end
    cmp++; if (ibuffer_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", ibuffer_empty); end
    cmp++; if (ibuffer_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", ibuffer_full); end
    cmp++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    drive_wr(2'b00, 0, 0, 0, 0);
    rst = 1;
    step();
    cmp++; if (count !== 5'd0 || rd_valid !== 2'b00) begin bad++; $display("FAIL post_reset_empty: got count %0d rd_valid %b want 0 00", count, rd_valid); end
  endtask

  task automatic test_pair_write();
    drive_wr(2'b11, 32'hbfc00000, 32'h24080001, 32'hbfc00004, 32'h24090002);
    rd_accept = 0;
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (rd_valid !== 2'b11) begin bad++; $display("FAIL pair_rd_valid: got %b want 11", rd_valid); end
    cmp++; if (rd_pc0 !== 32'hbfc00000) begin bad++; $display("FAIL pair_pc0: got %h want bfc00000", rd_pc0); end
    cmp++; if (rd_inst0 !== 32'h24080001) begin bad++; $display("FAIL pair_inst0: got %h want 24080001", rd_inst0); end
    cmp++; if (rd_pc1 !== 32'hbfc00004) begin bad++; $display("FAIL pair_pc1: got %h want bfc00004", rd_pc1); end
    cmp++; if (rd_inst1 !== 32'h24090002) begin bad++; $display("FAIL pair_inst1: got %h want 24090002", rd_inst1); end
    cmp++; if (count !== 5'd2) begin bad++; $display("FAIL pair_count: got %0d want 2", count); end
    cmp++; if (ibuffer_empty !== 1'b0) begin bad++; $display("FAIL pair_empty: got %b want 0", ibuffer_empty); end
  endtask

  task automatic test_full_overflow();
    do_flush();
    cmp++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    for (int i = 0; i < 6; i++) begin
      drive_wr(2'b11, 32'h100 + 8*i, 32'h500 + i, 32'h104 + 8*i, 32'h600 + i);
      step();
      if (i == 4) begin
        cmp++; if (ibuffer_full !== 1'b0) begin bad++; $display("FAIL full_at_10: got %b want 0", ibuffer_full); end
      end
    end
    cmp++; if (count !== 5'd12) begin bad++; $display("FAIL count_12: got %0d want 12", count); end
    cmp++; if (ibuffer_full !== 1'b1) begin bad++; $display("FAIL full_at_12: got %b want 1", ibuffer_full); end
    drive_wr(2'b11, 32'h130, 32'h506, 32'h134, 32'h606);
    step();
    cmp++; if (count !== 5'd14) begin bad++; $display("FAIL count_14: got %0d want 14", count); end
    drive_wr(2'b01, 32'h138, 32'h507, 0, 0);
    step();
    cmp++; if (count !== 5'd15) begin bad++; $display("FAIL count_15: got %0d want 15", count); end
    drive_wr(2'b11, 32'hdead0000, 32'hdead, 32'hdead0004, 32'hbeef);
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (count !== 5'd15) begin bad++; $display("FAIL drop_count: got %0d want 15", count); end
    cmp++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", overflow_err); end
    cmp++; if (rd_pc0 !== 32'h100) begin bad++; $display("FAIL drop_head_pc: got %h want 00000100", rd_pc0); end
    step();
    cmp++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle: got %b want 0", overflow_err); end
    cmp++; if (count !== 5'd15) begin bad++; $display("FAIL idle_count: got %0d want 15", count); end
    // a 01 write now fits exactly (count 15 -> 16)
    drive_wr(2'b01, 32'h13c, 32'h508, 0, 0);
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (count !== 5'd16 || overflow_err !== 1'b0) begin bad++; $display("FAIL fill_16: got count %0d ovf %b want 16 0", count, overflow_err); end
    // read two while writing two at full: admitted thanks to same-cycle reads
    drive_wr(2'b11, 32'h140, 32'h509, 32'h144, 32'h609);
    rd_accept = 2'd3;
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    rd_accept = 0;
    cmp++; if (count !== 5'd16 || overflow_err !== 1'b0) begin bad++; $display("FAIL full_rw: got count %0d ovf %b want 16 0", count, overflow_err); end
    cmp++; if (rd_pc0 !== 32'h108) begin bad++; $display("FAIL full_rw_head: got %h want 00000108", rd_pc0); end
  endtask

  task automatic test_compaction();
    do_flush();
    drive_wr(2'b01, 32'hbfc00008, 32'h11, 0, 0);
    step();
    drive_wr(2'b10, 0, 0, 32'hbfc0000c, 32'h22);
    rd_accept = 1;
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    rd_accept = 0;
    cmp++; if (count !== 5'd1) begin bad++; $display("FAIL comp_count: got %0d want 1", count); end
    cmp++; if (rd_pc0 !== 32'hbfc0000c) begin bad++; $display("FAIL comp_pc0: got %h want bfc0000c", rd_pc0); end
    cmp++; if (rd_inst0 !== 32'h22) begin bad++; $display("FAIL comp_inst0: got %h want 00000022", rd_inst0); end
    cmp++; if (rd_valid !== 2'b01) begin bad++; $display("FAIL comp_rd_valid: got %b want 01", rd_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    int max_cnt, ovf_seen, order_bad;
    do_flush();
    exp = 32'hbfc00000; max_cnt = 0; ovf_seen = 0; order_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        if (rd_valid[0]) begin
          if (rd_pc0 !== exp) begin order_bad++; $display("FAIL wrap_order0: got %h want %h", rd_pc0, exp); end
          exp += 4;
        end
        if (rd_valid[1]) begin
          if (rd_pc1 !== exp) begin order_bad++; $display("FAIL wrap_order1: got %h want %h", rd_pc1, exp); end
          exp += 4;
        end
      end
      drive_wr(2'b11, 32'hbfc00000 + 8*i, i, 32'hbfc00004 + 8*i, i + 100);
      rd_accept = (i == 0) ? 2'd0 : 2'd2;
      step();
      if (count > max_cnt) max_cnt = count;
      if (overflow_err) ovf_seen++;
    end
    drive_wr(2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 10 && !ibuffer_empty; k++) begin
      if (rd_valid[0]) begin
        if (rd_pc0 !== exp) begin order_bad++; $display("FAIL wrap_order0: got %h want %h", rd_pc0, exp); end
        exp += 4;
      end
      if (rd_valid[1]) begin
        if (rd_pc1 !== exp) begin order_bad++; $display("FAIL wrap_order1: got %h want %h", rd_pc1, exp); end
        exp += 4;
      end
      rd_accept = 2;
      step();
      if (overflow_err) ovf_seen++;
    end
    rd_accept = 0;
    cmp++; if (order_bad != 0) begin bad++; $display("FAIL wrap_order: got %0d out-of-order want 0", order_bad); end
    cmp++; if (exp !== 32'hbfc000a0) begin bad++; $display("FAIL wrap_total: got next pc %h want bfc000a0", exp); end
    cmp++; if (max_cnt > 4) begin bad++; $display("FAIL wrap_max_count: got %0d want <=4", max_cnt); end
    cmp++; if (ovf_seen != 0) begin bad++; $display("FAIL wrap_ovf: got %0d pulses want 0", ovf_seen); end
    cmp++; if (ibuffer_empty !== 1'b1) begin bad++; $display("FAIL wrap_drained: got %b want 1", ibuffer_empty); end
  endtask

  task automatic test_flush_collision();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      drive_wr(2'b11, 32'h400 + 8*i, i, 32'h404 + 8*i, i);
      step();
    end
    cmp++; if (count !== 5'd6) begin bad++; $display("FAIL pre_flush_count: got %0d want 6", count); end
    drive_wr(2'b11, 32'h900, 32'h9, 32'h904, 32'h9);
    rd_accept = 2; flush = 1;
    step();
    flush = 0; rd_accept = 0;
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (count !== 5'd0) begin bad++; $display("FAIL flush_col_count: got %0d want 0", count); end
    cmp++; if (ibuffer_empty !== 1'b1) begin bad++; $display("FAIL flush_col_empty: got %b want 1", ibuffer_empty); end
    cmp++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL flush_col_rd_valid: got %b want 00", rd_valid); end
    cmp++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL flush_col_ovf: got %b want 0", overflow_err); end
    drive_wr(2'b01, 32'h80000180, 32'h42, 0, 0);
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (rd_pc0 !== 32'h80000180) begin bad++; $display("FAIL post_flush_pc0: got %h want 80000180", rd_pc0); end
    cmp++; if (rd_valid !== 2'b01 || count !== 5'd1) begin bad++; $display("FAIL post_flush_state: got %b/%0d want 01/1", rd_valid, count); end
  endtask

  task automatic test_async_reset();
    drive_wr(2'b11, 32'h700, 1, 32'h704, 2);
    step();
    drive_wr(2'b00, 0, 0, 0, 0);
    cmp++; if (count !== 5'd3) begin bad++; $display("FAIL pre_async_count: got %0d want 3", count); end
    #2 rst = 0;
    #1;
    cmp++; if (count !== 5'd0 || rd_valid !== 2'b00) begin bad++; $display("FAIL async_reset: got count %0d rd_valid %b want 0 00", count, rd_valid); end
    step();
    rst = 1;
    step();
    cmp++; if (ibuffer_empty !== 1'b1) begin bad++; $display("FAIL async_release_empty: got %b want 1", ibuffer_empty); end
  endtask

  initial begin
    test_reset();
    test_pair_write();
    test_full_overflow();
    test_compaction();
    test_wrap();
    test_flush_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
